// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined integer square-root unit among NUM_REQ requesters.
// A requester tag follows each radical through the unit's fixed latency and steers the result back.
module sqrt_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int Q_WIDTH  = 16,
  parameter int R_WIDTH  = 17,
  parameter int PIPELINE = 5
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_radical,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [Q_WIDTH-1:0]       resp_q,
  output logic [R_WIDTH-1:0]       resp_remainder,
  output logic                     busy,
  output logic [3:0]               inflight,
  output logic [WIDTH-1:0]         sqrt_radical,
  output logic                     sqrt_ena,
  input  logic [Q_WIDTH-1:0]       sqrt_q,
  input  logic [R_WIDTH-1:0]       sqrt_remainder
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request is accepted in a cycle where req_valid[i] & req_ready[i];
  // req_ready is a combinational function of req_valid, so valid must not wait for ready.
  // Responses have no backpressure: resp_valid is a one-cycle pulse that must be sunk.

  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               grant_id;
  logic                          grant_any;
  logic [NUM_REQ-1:0]            grant;
  logic [WIDTH-1:0]              grant_radical;
  logic [PIPELINE:0]             tag_v;
  logic [PIPELINE:0][ID_W-1:0]   tag_id;
  logic [NUM_REQ-1:0]            resp_onehot;

  // Two passes: indices at or above ptr first, then the wrapped-around lower indices.
  always_comb begin
    grant         = '0;
    grant_id      = '0;
    grant_radical = '0;
    grant_any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && (i >= int'(ptr)) && req_valid[i]) begin
        grant_any     = 1'b1;
        grant[i]      = 1'b1;
        grant_id      = ID_W'(i);
        grant_radical = req_radical[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && (i < int'(ptr)) && req_valid[i]) begin
        grant_any     = 1'b1;
        grant[i]      = 1'b1;
        grant_id      = ID_W'(i);
        grant_radical = req_radical[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready   = grant;
  assign resp_onehot = NUM_REQ'(1) << tag_id[PIPELINE];
  assign busy        = (inflight != 4'd0);
  assign sqrt_ena    = ~aclr;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ptr          <= '0;
      sqrt_radical <= '0;
      tag_v        <= '0;
      tag_id       <= '0;
    end else begin
      if (grant_any) begin
        ptr          <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
        sqrt_radical <= grant_radical;
      end
      tag_v  <= {tag_v[PIPELINE-1:0], grant_any};
      tag_id <= {tag_id[PIPELINE-1:0], grant_id};
    end
  end

  // The last tag stage lines up with sqrt_q/sqrt_remainder from the attached unit.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      resp_valid     <= '0;
      resp_q         <= '0;
      resp_remainder <= '0;
    end else if (tag_v[PIPELINE]) begin
      resp_valid     <= resp_onehot;
      resp_q         <= sqrt_q;
      resp_remainder <= sqrt_remainder;
    end else begin
      resp_valid     <= '0;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      inflight <= 4'd0;
    end else begin
      case ({grant_any, |resp_valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural pipelined sqrt unit, directed vector table,
// multi-cycle sequences and a per-requester scoreboard of expected radicals.
module tb_sqrt_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int WIDTH    = 32;
  localparam int Q_WIDTH  = 16;
  localparam int R_WIDTH  = 17;
  localparam int PIPELINE = 5;
  localparam int LAT      = PIPELINE + 2;

  typedef struct {
    int          id;
    logic [31:0] rad;
    logic [15:0] q;
    logic [16:0] r;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     aclr = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_radical = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [Q_WIDTH-1:0]       resp_q;
  logic [R_WIDTH-1:0]       resp_remainder;
  logic                     busy;
  logic [3:0]               inflight;
  logic [WIDTH-1:0]         sqrt_radical;
  logic                     sqrt_ena;
  logic [Q_WIDTH-1:0]       sqrt_q;
  logic [R_WIDTH-1:0]       sqrt_remainder;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int outstanding = 0;
  logic [31:0] exp_q [NUM_REQ][$];
  int          exp_t [NUM_REQ][$];

  sqrt_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .Q_WIDTH(Q_WIDTH), .R_WIDTH(R_WIDTH), .PIPELINE(PIPELINE)
  ) dut (
    .clk(clk), .aclr(aclr), .req_valid(req_valid), .req_radical(req_radical),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_q(resp_q),
    .resp_remainder(resp_remainder), .busy(busy), .inflight(inflight),
    .sqrt_radical(sqrt_radical), .sqrt_ena(sqrt_ena), .sqrt_q(sqrt_q),
    .sqrt_remainder(sqrt_remainder)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- attached sqrt unit model ----------------
  function automatic logic [32:0] isqrt(input logic [31:0] x);
    longint unsigned n, res, b;
    n = longint'(x);
    res = 0;
    b = 64'h4000_0000;
    while (b > n) b = b >> 2;
    while (b != 0) begin
      if (n >= res + b) begin
        n   = n - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return {res[15:0], n[16:0]};
  endfunction

  logic [32:0] s_pipe [PIPELINE];
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < PIPELINE; k++) s_pipe[k] <= '0;
    end else begin
      s_pipe[0] <= isqrt(sqrt_radical);
      for (int k = 1; k < PIPELINE; k++) s_pipe[k] <= s_pipe[k-1];
    end
  end
  assign sqrt_q         = s_pipe[PIPELINE-1][32:17];
  assign sqrt_remainder = s_pipe[PIPELINE-1][16:0];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (aclr) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        exp_q[r].delete();
        exp_t[r].delete();
      end
      outstanding = 0;
    end else begin
      check("sb_inflight", 64'(inflight), 64'(outstanding));
      check("sb_busy", 64'(busy), 64'(outstanding != 0));
      check("sb_ready_legal", 64'(req_ready & ~req_valid), 64'(0));
      if (req_valid != 0) check("sb_ready_onehot", 64'($onehot(req_ready)), 64'(1));
      if (resp_valid != 0) begin
        if (!$onehot(resp_valid)) begin
          check("sb_resp_onehot", 64'(resp_valid), 64'(0));
        end else begin
          for (int r = 0; r < NUM_REQ; r++) begin
            if (resp_valid[r]) begin
              if (exp_q[r].size() == 0) begin
                check("sb_resp_unexpected", 64'(resp_valid), 64'(0));
              end else begin
                logic [31:0] rad;
                int t0;
                rad = exp_q[r].pop_front();
                t0  = exp_t[r].pop_front();
                check("sb_latency", 64'(cyc - t0), 64'(LAT));
                check("sb_q2_plus_r", 64'(resp_q) * 64'(resp_q) + 64'(resp_remainder), 64'(rad));
                check("sb_r_le_2q", 64'(64'(resp_remainder) <= 2 * 64'(resp_q)), 64'(1));
                outstanding--;
              end
            end
          end
        end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          exp_q[r].push_back(req_radical[r*WIDTH +: WIDTH]);
          exp_t[r].push_back(cyc);
          outstanding++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic single(input vec_t v);
    next_cycle();
    req_valid = 4'(1 << v.id);
    req_radical[v.id*WIDTH +: WIDTH] = v.rad;
    sample();
    check("single_ready", 64'(req_ready), 64'(1 << v.id));
    for (int k = 1; k <= LAT; k++) begin
      next_cycle();
      req_valid = '0;
      sample();
      if (k == 1) begin
        check("single_sqrt_radical", 64'(sqrt_radical), 64'(v.rad));
        check("single_inflight_1", 64'(inflight), 64'(1));
      end
      if (k < LAT) check("single_early_resp", 64'(resp_valid), 64'(0));
    end
    check("single_resp_valid", 64'(resp_valid), 64'(1 << v.id));
    check("single_q", 64'(resp_q), 64'(v.q));
    check("single_r", 64'(resp_remainder), 64'(v.r));
    next_cycle();
    sample();
    check("single_resp_pulse", 64'(resp_valid), 64'(0));
    check("single_inflight_0", 64'(inflight), 64'(0));
    check("single_busy_0", 64'(busy), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [8];
  vec_t quad [4];

  initial begin
    vecs[0] = '{2, 32'd26,         16'd5,     17'd1};
    vecs[1] = '{0, 32'd0,          16'd0,     17'd0};
    vecs[2] = '{1, 32'd1,          16'd1,     17'd0};
    vecs[3] = '{2, 32'd144,        16'd12,    17'd0};
    vecs[4] = '{3, 32'hFFFF_FFFF,  16'd65535, 17'd131070};
    vecs[5] = '{1, 32'd99,         16'd9,     17'd18};
    vecs[6] = '{0, 32'd2,          16'd1,     17'd1};
    vecs[7] = '{3, 32'd1000000,    16'd1000,  17'd0};
    quad[0] = '{0, 32'd0,          16'd0,     17'd0};
    quad[1] = '{1, 32'd1,          16'd1,     17'd0};
    quad[2] = '{2, 32'd144,        16'd12,    17'd0};
    quad[3] = '{3, 32'hFFFF_FFFF,  16'd65535, 17'd131070};

    // Reset values, with arbitration live under reset
    aclr = 1'b1;
    req_valid = 4'b1010;
    repeat (2) next_cycle();
    sample();
    check("rst_ready", 64'(req_ready), 64'(4'b0010));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_q", 64'(resp_q), 64'(0));
    check("rst_resp_r", 64'(resp_remainder), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_sqrt_radical", 64'(sqrt_radical), 64'(0));
    check("rst_sqrt_ena", 64'(sqrt_ena), 64'(0));
    next_cycle();
    aclr = 1'b0;
    req_valid = '0;
    sample();
    check("sqrt_ena_run", 64'(sqrt_ena), 64'(1));

    // Directed single-request table; last entry is requester 3 so ptr returns to 0
    for (int i = 0; i < 8; i++) single(vecs[i]);

    // All four valid at once, each held until granted
    begin
      logic [3:0] pend;
      pend = 4'hF;
      for (int r = 0; r < 4; r++) req_radical[r*WIDTH +: WIDTH] = quad[r].rad;
      for (int t = 0; t <= 10; t++) begin
        next_cycle();
        req_valid = pend;
        sample();
        if (t < 4) begin
          check("quad_grant", 64'(req_ready), 64'(1 << t));
          pend[t] = 1'b0;
        end
        if (t >= LAT) begin
          check("quad_resp_valid", 64'(resp_valid), 64'(1 << (t - LAT)));
          check("quad_q", 64'(resp_q), 64'(quad[t-LAT].q));
          check("quad_r", 64'(resp_remainder), 64'(quad[t-LAT].r));
        end
      end
    end

    // Requesters 1 and 3 continuously valid for 20 cycles: strict alternation
    begin
      int n1, n3;
      n1 = 0;
      n3 = 0;
      for (int t = 0; t < 20 + LAT + 1; t++) begin
        next_cycle();
        req_valid = (t < 20) ? 4'b1010 : 4'b0000;
        req_radical[1*WIDTH +: WIDTH] = $urandom();
        req_radical[3*WIDTH +: WIDTH] = $urandom();
        sample();
        if (t < 20) begin
          check("alt_grant", 64'(req_ready), 64'((t % 2 == 0) ? 4'b0010 : 4'b1000));
          if (req_ready[1]) n1++;
          if (req_ready[3]) n3++;
        end
      end
      check("alt_count_1", 64'(n1), 64'(10));
      check("alt_count_3", 64'(n3), 64'(10));
    end

    // Back-to-back from requester 0: radicals n^2, n = 1..16
    for (int t = 0; t < 16 + LAT + 1; t++) begin
      next_cycle();
      req_valid = (t < 16) ? 4'b0001 : 4'b0000;
      req_radical[0 +: WIDTH] = 32'((t + 1) * (t + 1));
      sample();
      if (t < 16) check("b2b_grant", 64'(req_ready), 64'(1));
      if (t >= LAT && t < LAT + 16) begin
        check("b2b_resp_valid", 64'(resp_valid), 64'(1));
        check("b2b_q", 64'(resp_q), 64'(t - LAT + 1));
        check("b2b_r", 64'(resp_remainder), 64'(0));
      end
      if (t >= LAT && t <= 16) check("b2b_inflight_sat", 64'(inflight), 64'(7));
      if (t == LAT + 16) check("b2b_tail", 64'(resp_valid), 64'(0));
    end

    // Reset three cycles after three grants discards everything in flight
    for (int t = 0; t <= 12; t++) begin
      next_cycle();
      req_valid = (t < 3) ? 4'b0100 : 4'b0000;
      req_radical[2*WIDTH +: WIDTH] = 32'(50 + 10 * t);
      aclr = (t == 5);
      sample();
      if (t < 3) check("rst_mid_grant", 64'(req_ready), 64'(4'b0100));
      if (t == 4) check("rst_mid_inflight_pre", 64'(inflight), 64'(3));
      if (t == 5) begin
        check("rst_mid_inflight", 64'(inflight), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
      end
      if (t >= 5) check("rst_mid_no_resp", 64'(resp_valid), 64'(0));
    end
    begin
      vec_t v;
      v = '{1, 32'd49, 16'd7, 17'd0};
      single(v);
    end

    // Random traffic, then drain
    for (int t = 0; t < 400; t++) begin
      next_cycle();
      req_valid = 4'($urandom_range(0, 15));
      for (int r = 0; r < NUM_REQ; r++) req_radical[r*WIDTH +: WIDTH] = $urandom();
      sample();
    end
    next_cycle();
    req_valid = '0;
    repeat (LAT + 2) next_cycle();
    sample();
    for (int r = 0; r < NUM_REQ; r++) check("drain_queue_empty", 64'(exp_q[r].size()), 64'(0));
    check("drain_inflight", 64'(inflight), 64'(0));
    check("drain_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
